// File: rtl/sdram_bist_pkg.sv
// Shared types and LFSR helper for the sdram_bist memory self-test.
package sdram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD      = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    // Galois right-shift step; the polynomial is applied when bit 0 shifts out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/sdram_bist_lfsr.sv
// Pattern generator shared by the write and read-back phases.
module sdram_bist_lfsr
    import sdram_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    // Reload takes priority so the last write can rewind straight to the seed.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            value <= seed;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/sdram_bist.sv
// Power-on self-test initiator for the sdram_core user interface:
// writes an LFSR pattern, reads it back and reports the comparison result.
module sdram_bist
    import sdram_bist_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_WORDS  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [31:0]           SEED       = 32'h0000ACE1,
    parameter int                    RD_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [15:0]             err_count,
    output logic [ADDR_WIDTH-1:0]   first_err_addr,
    output logic [ADDR_WIDTH-1:0]   core_addr,
    output logic [DATA_WIDTH-1:0]   core_write_data,
    output logic [DATA_WIDTH/8-1:0] core_wr,
    output logic                    core_rd,
    input  logic                    core_rdy,
    input  logic                    core_valid,
    input  logic [DATA_WIDTH-1:0]   core_read_data
);

    localparam int                    IDX_W     = 21;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam int                    TO_W      = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(RD_TIMEOUT - 1);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [TO_W-1:0]         to_cnt;
    logic [31:0]             lfsr_value;
    logic [DATA_WIDTH-1:0]   word;
    logic                    lfsr_load;
    logic                    lfsr_advance;
    logic                    last;
    logic                    mismatch;

    assign word     = lfsr_value[DATA_WIDTH-1:0];
    assign last     = (idx == LAST_IDX);
    assign mismatch = (core_read_data != word);

    sdram_bist_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .advance (lfsr_advance),
        .seed    (SEED),
        .value   (lfsr_value)
    );

    // LFSR sequencing: rewind at run start and after the final write,
    // step on every write accept and every read return.
    always_comb begin
        lfsr_load    = 1'b0;
        lfsr_advance = 1'b0;
        case (state)
            ST_IDLE:    lfsr_load    = start;
            ST_WR:      begin
                            lfsr_load    = core_rdy && last;
                            lfsr_advance = core_rdy;
                        end
            ST_RD_WAIT: lfsr_advance = core_valid;
            default:    ;
        endcase
    end

    // Requests are decoded from the state so they hold steady until accepted.
    always_comb begin
        core_wr         = '0;
        core_rd         = 1'b0;
        core_addr       = '0;
        core_write_data = '0;
        if (state == ST_WR) begin
            core_wr         = '1;
            core_addr       = addr;
            core_write_data = word;
        end else if (state == ST_RD) begin
            core_rd   = 1'b1;
            core_addr = addr;
        end
    end

    // Main sequencer: run control, address walk, timeout and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= '0;
            addr           <= '0;
            to_cnt         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        idx            <= '0;
                        addr           <= BASE_ADDR;
                        state          <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (core_rdy) begin
                        if (last) begin
                            idx   <= '0;
                            addr  <= BASE_ADDR;
                            state <= ST_RD;
                        end else begin
                            idx  <= idx + 1'b1;
                            addr <= addr + ADDR_STEP;
                        end
                    end
                end
                ST_RD: begin
                    if (core_rdy) begin
                        to_cnt <= '0;
                        state  <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    // A return on the expiry cycle still counts as a return.
                    if (core_valid) begin
                        if (mismatch) begin
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'd1;
                            end
                            if (err_count == '0) begin
                                first_err_addr <= addr;
                            end
                        end
                        if (last) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= !mismatch && (err_count == '0);
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            addr  <= addr + ADDR_STEP;
                            state <= ST_RD;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        pass    <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_bist.sv
// Scoreboard bench for sdram_bist with a behavioural sdram_core responder.
module tb_sdram_bist;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        bit          pass;
        bit          timeout;
        logic [15:0] err;
        logic [31:0] first;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;
    logic [31:0] core_addr;
    logic [31:0] core_write_data;
    logic [3:0]  core_wr;
    logic        core_rd;
    logic        core_rdy = 1'b0;
    logic        core_valid = 1'b0;
    logic [31:0] core_read_data = '0;

    int tests = 0;
    int fails = 0;
    int accepts = 0;
    int cyc = 0;
    int rd_acc_cyc = -1;
    int done_cyc = -1;

    // responder knobs
    int stall_cycles = 0;
    bit corrupt = 0;
    bit never_valid = 0;
    bit spurious = 0;

    req_t req_q[$];
    res_t res_q[$];
    logic [31:0] exp_data [4] = '{32'h0000ACE1, 32'h80205673, 32'hC0302B3A, 32'h6018159D};
    logic [31:0] mem [4];

    sdram_bist #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_WORDS  (4),
        .BASE_ADDR  (32'h0),
        .SEED       (32'h0000ACE1),
        .RD_TIMEOUT (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .timeout         (timeout),
        .err_count       (err_count),
        .first_err_addr  (first_err_addr),
        .core_addr       (core_addr),
        .core_write_data (core_write_data),
        .core_wr         (core_wr),
        .core_rd         (core_rd),
        .core_rdy        (core_rdy),
        .core_valid      (core_valid),
        .core_read_data  (core_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural responder: stalls, stores writes, returns reads one cycle after accept.
    initial begin : responder
        bit          ret_pend = 0;
        logic [1:0]  ret_idx = '0;
        int          stall_cnt = 0;
        forever begin
            @(negedge clk);
            core_valid = 1'b0;
            core_rdy   = 1'b0;
            if (rst) begin
                stall_cnt = 0;
                ret_pend  = 0;
                continue;
            end
            if (ret_pend) begin
                if (!never_valid) begin
                    core_valid     = 1'b1;
                    core_read_data = mem[ret_idx] ^ ((corrupt && ret_idx == 2'd2) ? 32'h1 : 32'h0);
                end
                ret_pend = 0;
            end else if (spurious && core_wr != 4'h0) begin
                core_valid     = 1'b1;
                core_read_data = 32'hDEADBEEF;
            end
            if (core_wr != 4'h0 || core_rd) begin
                if (stall_cnt < stall_cycles) begin
                    stall_cnt++;
                end else begin
                    core_rdy  = 1'b1;
                    stall_cnt = 0;
                    if (core_wr != 4'h0) begin
                        mem[core_addr[3:2]] = core_write_data;
                    end else begin
                        ret_pend = 1;
                        ret_idx  = core_addr[3:2];
                    end
                end
            end
        end
    end

    // Monitor: pops expected requests on each accept, expected results on done rising.
    initial begin : monitor
        bit          held_v = 0;
        logic [31:0] h_addr = '0;
        logic [31:0] h_data = '0;
        logic [3:0]  h_wr = '0;
        logic        h_rd = 1'b0;
        logic        prev_done = 1'b0;
        req_t        r;
        res_t        e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                held_v    = 0;
                prev_done = done;
                continue;
            end
            if (held_v) begin
                chk("stall_hold_addr", core_addr, h_addr);
                chk("stall_hold_data", core_write_data, h_data);
                chk("stall_hold_cmd", {core_wr, core_rd}, {h_wr, h_rd});
            end
            held_v = 0;
            if (core_wr != 4'h0 && core_rd) begin
                chk("wr_rd_exclusive", 1, 0);
            end
            if (core_wr != 4'h0 || core_rd) begin
                if (core_rdy) begin
                    accepts++;
                    if (req_q.size() == 0) begin
                        chk("unexpected_request", {core_wr, core_rd, core_addr}, 0);
                    end else begin
                        r = req_q.pop_front();
                        chk("req_type", {core_wr, core_rd}, r.wr ? 5'b11110 : 5'b00001);
                        chk("req_addr", core_addr, r.addr);
                        if (r.wr) chk("req_wdata", core_write_data, r.data);
                        if (!r.wr && rd_acc_cyc < 0) rd_acc_cyc = cyc + 1;
                    end
                end else begin
                    held_v = 1;
                    h_addr = core_addr;
                    h_data = core_write_data;
                    h_wr   = core_wr;
                    h_rd   = core_rd;
                end
            end
            if (done && !prev_done) begin
                done_cyc = cyc;
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = res_q.pop_front();
                    chk("res_pass", pass, e.pass);
                    chk("res_timeout", timeout, e.timeout);
                    chk("res_err_count", err_count, e.err);
                    chk("res_first_err_addr", first_err_addr, e.first);
                    chk("res_busy_clear", busy, 0);
                end
            end
            prev_done = done;
        end
    end

    task automatic push_req(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        req_t r;
        r.wr = wr; r.addr = addr; r.data = data;
        req_q.push_back(r);
    endtask

    task automatic push_res(input bit p, input bit t, input logic [15:0] err, input logic [31:0] first);
        res_t e;
        e.pass = p; e.timeout = t; e.err = err; e.first = first;
        res_q.push_back(e);
    endtask

    task automatic push_writes();
        for (int i = 0; i < 4; i++) push_req(1, 32'(i * 4), exp_data[i]);
    endtask

    task automatic push_reads(input int n);
        for (int i = 0; i < n; i++) push_req(0, 32'(i * 4), '0);
    endtask

    task automatic do_start();
        accepts    = 0;
        rd_acc_cyc = -1;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk); #2;
        chk("busy_after_start", busy, 1);
        chk("wr_req_latency", core_wr, 4'hF);
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", done, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_end(input int exp_acc);
        chk("req_queue_drained", req_q.size(), 0);
        chk("res_queue_drained", res_q.size(), 0);
        chk("accept_count", accepts, exp_acc);
        chk("done_level_held", done, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_first_err_addr"}, first_err_addr, 0);
        chk({tag, "_core_addr"}, core_addr, 0);
        chk({tag, "_core_write_data"}, core_write_data, 0);
        chk({tag, "_core_wr"}, core_wr, 0);
        chk({tag, "_core_rd"}, core_rd, 0);
    endtask

    initial begin : stimulus
        int n;
        repeat (3) @(posedge clk);
        #2;
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // clean run, responder always ready
        push_writes(); push_reads(4); push_res(1, 0, 16'd0, 32'h0);
        do_start();
        wait_done(300);
        check_end(8);

        // 5-cycle stall on every request
        stall_cycles = 5;
        push_writes(); push_reads(4); push_res(1, 0, 16'd0, 32'h0);
        do_start();
        wait_done(600);
        check_end(8);

        // word 2 read back with bit 0 flipped
        stall_cycles = 0;
        corrupt = 1;
        push_writes(); push_reads(4); push_res(0, 0, 16'd1, 32'h8);
        do_start();
        wait_done(300);
        check_end(8);
        corrupt = 0;

        // no read ever returns
        never_valid = 1;
        push_writes(); push_reads(1); push_res(0, 1, 16'd0, 32'h0);
        do_start();
        wait_done(300);
        check_end(5);
        chk("timeout_delay", done_cyc - rd_acc_cyc, 16);
        never_valid = 0;

        // reset during the write phase, then rerun
        stall_cycles = 2;
        push_writes();
        do_start();
        n = 0;
        while (accepts < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_wr", accepts >= 2, 1);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2;
        chk_zero("midrun_reset");
        @(posedge clk); #2;
        chk_zero("midrun_reset_hold");
        req_q.delete();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        push_writes(); push_reads(4); push_res(1, 0, 16'd0, 32'h0);
        do_start();
        wait_done(400);
        check_end(8);

        // start pulses while busy plus spurious returns during writes
        stall_cycles = 1;
        spurious = 1;
        push_writes(); push_reads(4); push_res(1, 0, 16'd0, 32'h0);
        do_start();
        for (int k = 0; k < 3; k++) begin
            repeat (3) @(posedge clk);
            #2 start = 1'b1;
            @(posedge clk); #2 start = 1'b0;
            chk("busy_during_run", busy, 1);
        end
        wait_done(400);
        check_end(8);
        spurious = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
